fir_movsum_pipe: RTL

FIR_MOVSUM_PIPE -- requirements
Module: fir_movsum_pipe

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_movsum_pipe_if.sv | 37 +++
 rtl/fir_add_stage.sv | 34 +++
 rtl/fir_movsum_pipe.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and width helpers for the moving-sum FIR pipeline.
package fir_pkg;

  localparam int DEF_W    = 16;
  localparam int DEF_TAPS = 8;

  // Number of adder-tree levels for a power-of-two tap count.
  function automatic int log2_taps(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Output width: one extra bit per tree level, so the sum can never overflow.
  function automatic int out_width(input int w, input int taps);
    return w + log2_taps(taps);
  endfunction

endpackage

// File: rtl/fir_movsum_pipe_if.sv
// Sample-in / sum-out bus of the moving-sum pipeline.
// The avg signal exists only when FIR_MOVSUM_AVG_EN is defined.
interface fir_movsum_pipe_if
  import fir_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int TAPS = DEF_TAPS
);

  localparam int OW = out_width(W, TAPS);

  logic          in_valid;
  logic [W-1:0]  a;
  logic          clear;
  logic [OW-1:0] s;
  logic          out_valid;
`ifdef FIR_MOVSUM_AVG_EN
  logic [W-1:0]  avg;
`endif

  modport master (
    output in_valid, a, clear,
    input  s, out_valid
`ifdef FIR_MOVSUM_AVG_EN
    , input avg
`endif
  );

  modport slave (
    input  in_valid, a, clear,
    output s, out_valid
`ifdef FIR_MOVSUM_AVG_EN
    , output avg
`endif
  );

endinterface

// File: rtl/fir_add_stage.sv
// One registered level of the adder tree: N_IN operands of IN_W bits become
// N_IN/2 pairwise sums of IN_W+1 bits, with a valid bit travelling alongside.
module fir_add_stage #(
  parameter int IN_W = 16,
  parameter int N_IN = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [N_IN*IN_W-1:0]         din,
  output logic                         out_valid,
  output logic [(N_IN/2)*(IN_W+1)-1:0] dout
);

  localparam int N_OUT = N_IN / 2;
  localparam int OUT_W = IN_W + 1;

  // Pairwise sums and valid bit; flush kills the in-flight valid only.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid & ~flush;
      for (int i = 0; i < N_OUT; i++) begin
        dout[i*OUT_W +: OUT_W] <= OUT_W'(din[(2*i)*IN_W +: IN_W])
                                + OUT_W'(din[(2*i+1)*IN_W +: IN_W]);
      end
    end
  end

endmodule

// File: rtl/fir_movsum_pipe.sv
// Moving sum of the last TAPS accepted samples through a registered binary
// adder tree; latency from accept to output is log2(TAPS)+1 cycles.
// Optional feature: define FIR_MOVSUM_AVG_EN to add a rounded average output.
module fir_movsum_pipe
  import fir_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int TAPS = DEF_TAPS
) (
  input logic              clk,
  input logic              reset,
  fir_movsum_pipe_if.slave bus
);

  localparam int LT = log2_taps(TAPS);
  localparam int OW = out_width(W, TAPS);

  localparam logic [LT:0] FULL    = (LT+1)'(TAPS);
  localparam logic [LT:0] FULL_M1 = (LT+1)'(TAPS - 1);
  localparam logic [LT:0] ONE     = (LT+1)'(1);

  logic [W-1:0]      line [TAPS];
  logic [LT:0]       fill;
  logic              line_valid;
  logic [TAPS*W-1:0] line_flat;
  logic [OW-1:0]     tree_sum;
  logic              tree_valid;

  // Delay line, saturating fill counter and the valid bit entering the tree.
  // NOTE: the delay line is a flop array, not RAM, so it is reset so sums restart from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) line[i] <= '0;
      fill       <= '0;
      line_valid <= 1'b0;
    end else if (bus.clear) begin
      for (int i = 0; i < TAPS; i++) line[i] <= '0;
      if (bus.in_valid) begin
        line[0] <= bus.a;
        fill    <= ONE;
      end else begin
        fill    <= '0;
      end
      line_valid <= 1'b0;
    end else if (bus.in_valid) begin
      line[0] <= bus.a;
      for (int i = 1; i < TAPS; i++) line[i] <= line[i-1];
      if (fill != FULL) fill <= fill + ONE;
      line_valid <= (fill >= FULL_M1);
    end else begin
      line_valid <= 1'b0;
    end
  end

  // Flatten the delay line into the first tree level's operand vector.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    line_flat = '0;
    for (int i = 0; i < TAPS; i++) line_flat[i*W +: W] = line[i];
  end

  // LT registered adder levels, each one bit wider than the last.
  for (genvar k = 0; k < LT; k++) begin : g_lvl
    localparam int IN_W = W + k;
    localparam int N_IN = TAPS >> k;

    logic [N_IN*IN_W-1:0]         din;
    logic                         din_valid;
    logic [(N_IN/2)*(IN_W+1)-1:0] dout;
    logic                         dout_valid;

    if (k == 0) begin : g_first
      assign din       = line_flat;
      assign din_valid = line_valid;
    end else begin : g_next
      assign din       = g_lvl[k-1].dout;
      assign din_valid = g_lvl[k-1].dout_valid;
    end

    fir_add_stage #(
      .IN_W (IN_W),
      .N_IN (N_IN)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.clear),
      .in_valid  (din_valid),
      .din       (din),
      .out_valid (dout_valid),
      .dout      (dout)
    );
  end

  assign tree_sum   = g_lvl[LT-1].dout;
  assign tree_valid = g_lvl[LT-1].dout_valid;

`ifdef FIR_MOVSUM_AVG_EN
  // Round half-up; sum + TAPS/2 stays below 2^OW, so no extra bit is needed.
  logic [OW-1:0] rounded;
  logic [W-1:0]  avg_next;
  assign rounded  = tree_sum + OW'(TAPS / 2);
  assign avg_next = W'(rounded >> LT);
`endif

  // Output register: s (and avg) load only with a surviving valid, else hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.s         <= '0;
      bus.out_valid <= 1'b0;
`ifdef FIR_MOVSUM_AVG_EN
      bus.avg       <= '0;
`endif
    end else begin
      bus.out_valid <= tree_valid & ~bus.clear;
      if (tree_valid && !bus.clear) begin
        bus.s   <= tree_sum;
`ifdef FIR_MOVSUM_AVG_EN
        bus.avg <= avg_next;
`endif
      end
    end
  end

endmodule
